// File: rtl/iob_fifo_rd_stream.sv
// iob_fifo_rd_stream: drains an iob_fifo_sync read port (1-cycle read latency) into a
// valid/ready stream through a 2-entry skid buffer, sustaining one word per cycle.
// Optional packet framing (m_tlast from a cfg_len word counter): define IOB_FIFO_RD_STREAM_LAST_EN.
module iob_fifo_rd_stream #(
  parameter int unsigned DATA_W = 32
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
  ,
  parameter int unsigned LEN_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              rst,
  input  logic              en,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_r_data,
  input  logic              fifo_r_empty,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
  output logic              m_tlast,
  input  logic [LEN_W-1:0]  cfg_len,
`endif
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              inflight_q, inflight_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] slot0_q, slot0_d;
  logic [DATA_W-1:0] slot1_q, slot1_d;
  logic              pop;
  logic              push;
  logic [2:0]        occ_after;
  logic              wr0;
  logic              wr1;
  logic              shift;
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              last0_q, last0_d;
  logic              last1_q, last1_d;
  logic              last_in;
`endif

  // Next-state, slot steering, read gating and synchronous clear
  always_comb begin
    state_d    = state_q;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    wr0        = 1'b0;
    wr1        = 1'b0;
    shift      = 1'b0;
    pop        = valid_q & m_tready;
    push       = inflight_q;
    // Occupancy after this cycle's pop plus the word already in flight; no wrap at 3 bits
    occ_after  = 3'(state_q) + 3'(inflight_q) - 3'(pop);
    fifo_r_en  = en & ~rst & ~fifo_r_empty & (occ_after <= 3'd1);
    inflight_d = fifo_r_en;

    case (state_q)
      S_EMPTY: begin
        if (push) begin
          wr0     = 1'b1;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        case ({push, pop})
          2'b10: begin
            wr1     = 1'b1;
            state_d = S_TWO;
          end
          2'b01:   state_d = S_EMPTY;
          2'b11:   wr0 = 1'b1;
          default: state_d = S_ONE;
        endcase
      end
      S_TWO: begin
        // push without pop cannot happen here: reads are gated on occ_after
        if (pop) begin
          shift = 1'b1;
          if (push) wr1 = 1'b1;
          else      state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (wr0)        slot0_d = fifo_r_data;
    else if (shift) slot0_d = slot1_q;
    if (wr1)        slot1_d = fifo_r_data;

`ifdef IOB_FIFO_RD_STREAM_LAST_EN
    cnt_d   = cnt_q;
    last0_d = last0_q;
    last1_d = last1_q;
    // cfg_len of zero means an unbounded stream: never flag a last word
    last_in = (cfg_len != '0) && (cnt_q == cfg_len - LEN_W'(1));
    if (push) cnt_d = last_in ? '0 : cnt_q + LEN_W'(1);
    if (wr0)        last0_d = last_in;
    else if (shift) last0_d = last1_q;
    if (wr1)        last1_d = last_in;
`endif

    if (rst) begin
      state_d    = S_EMPTY;
      inflight_d = 1'b0;
      slot0_d    = '0;
      slot1_d    = '0;
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
      cnt_d      = '0;
      last0_d    = 1'b0;
      last1_d    = 1'b0;
`endif
    end

    valid_d = (state_d != S_EMPTY);
  end

  // State and skid-buffer registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_EMPTY;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      slot0_q    <= '0;
      slot1_q    <= '0;
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
      cnt_q      <= '0;
      last0_q    <= 1'b0;
      last1_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
      cnt_q      <= cnt_d;
      last0_q    <= last0_d;
      last1_q    <= last1_d;
`endif
    end
  end

  assign m_tdata   = slot0_q;
  assign m_tvalid  = valid_q;
  assign occupancy = 2'(state_q);
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
  assign m_tlast   = last0_q;
`endif

endmodule

// File: tb/tb_iob_fifo_rd_stream.sv
// Bench for iob_fifo_rd_stream: a behavioural FIFO whose word k holds value k+1, directed
// scenario tasks with inline checks. Packet-framing scenario runs when
// IOB_FIFO_RD_STREAM_LAST_EN is defined.
module tb_iob_fifo_rd_stream;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 16;

  logic              clk = 1'b0;
  logic              arst_n = 1'b1;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              m_tready = 1'b0;
  logic              fifo_r_en;
  logic [DATA_W-1:0] fifo_r_data = '0;
  logic              fifo_r_empty = 1'b1;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic [1:0]        occupancy;
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
  logic              m_tlast;
  logic [LEN_W-1:0]  cfg_len = '0;
`endif

  int nvec = 0;
  int nerr = 0;
  int avail = 0;    // words ever written into the model FIFO
  int rd_ptr = 0;   // words ever read out of the model FIFO
  int overrun = 0;  // reads issued while the model FIFO was empty
  int exp_w = 1;    // value of the next word the stream should deliver

  iob_fifo_rd_stream #(
    .DATA_W(DATA_W)
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
    , .LEN_W(LEN_W)
`endif
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .rst         (rst),
    .en          (en),
    .fifo_r_en   (fifo_r_en),
    .fifo_r_data (fifo_r_data),
    .fifo_r_empty(fifo_r_empty),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
    .m_tlast     (m_tlast),
    .cfg_len     (cfg_len),
`endif
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  // Model of iob_fifo_sync read side: registered data and registered empty flag
  always @(posedge clk) begin
    if (fifo_r_en) begin
      if (rd_ptr >= avail) overrun = overrun + 1;
      fifo_r_data <= DATA_W'(rd_ptr + 1);
      rd_ptr = rd_ptr + 1;
    end
    fifo_r_empty <= (rd_ptr >= avail);
  end

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec++; if (m_tvalid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %0b want 0", m_tvalid); end
    nvec++; if (m_tdata !== '0) begin nerr++; $display("FAIL reset_data: got %0h want 0", m_tdata); end
    nvec++; if (occupancy !== 2'd0) begin nerr++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    arst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);
    nvec++; if (fifo_r_en !== 1'b0) begin nerr++; $display("FAIL reset_empty_rd: got %0b want 0", fifo_r_en); end
  endtask

  task automatic test_stream();
    en = 1'b1; m_tready = 1'b1;
    avail += 8;
    @(negedge clk);
    nvec++; if (fifo_r_en !== 1'b1) begin nerr++; $display("FAIL stream_rd_en: got %0b want 1", fifo_r_en); end
    nvec++; if (m_tvalid !== 1'b0) begin nerr++; $display("FAIL stream_lat_t: got %0b want 0", m_tvalid); end
    @(negedge clk);
    nvec++; if (m_tvalid !== 1'b0) begin nerr++; $display("FAIL stream_lat_t1: got %0b want 0", m_tvalid); end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      nvec++;
      if (m_tvalid !== 1'b1 || m_tdata !== DATA_W'(exp_w + i)) begin
        nerr++; $display("FAIL stream_word%0d: got v=%0b d=%0h want v=1 d=%0h", i, m_tvalid, m_tdata, exp_w + i);
      end
      @(negedge clk);
    end
    exp_w += 8;
    nvec++; if (m_tvalid !== 1'b0) begin nerr++; $display("FAIL stream_end: got %0b want 0", m_tvalid); end
  endtask

  task automatic test_backpressure();
    m_tready = 1'b0;
    avail += 4;
    repeat (6) @(negedge clk);
    nvec++; if (occupancy !== 2'd2) begin nerr++; $display("FAIL bp_occ: got %0d want 2", occupancy); end
    nvec++; if (fifo_r_en !== 1'b0) begin nerr++; $display("FAIL bp_rd_en: got %0b want 0", fifo_r_en); end
    repeat (3) @(negedge clk);
    nvec++; if (m_tvalid !== 1'b1 || m_tdata !== DATA_W'(exp_w)) begin
      nerr++; $display("FAIL bp_hold: got v=%0b d=%0h want v=1 d=%0h", m_tvalid, m_tdata, exp_w);
    end
    nvec++; if (rd_ptr !== avail - 2) begin nerr++; $display("FAIL bp_reads: got %0d want %0d", rd_ptr, avail - 2); end
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (m_tvalid !== 1'b1 || m_tdata !== DATA_W'(exp_w + i)) begin
        nerr++; $display("FAIL bp_drain%0d: got v=%0b d=%0h want v=1 d=%0h", i, m_tvalid, m_tdata, exp_w + i);
      end
      @(negedge clk);
    end
    exp_w += 4;
    nvec++; if (m_tvalid !== 1'b0) begin nerr++; $display("FAIL bp_end: got %0b want 0", m_tvalid); end
  endtask

  task automatic test_toggle();
    int got = 0;
    int max_occ = 0;
    avail += 16;
    for (int c = 0; c < 200 && got < 16; c++) begin
      m_tready = (c % 2 == 0);
      #1;
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (m_tvalid && m_tready) begin
        nvec++;
        if (m_tdata !== DATA_W'(exp_w)) begin
          nerr++; $display("FAIL toggle_word%0d: got %0h want %0h", got, m_tdata, exp_w);
        end
        exp_w++; got++;
      end
      @(negedge clk);
    end
    m_tready = 1'b1;
    nvec++; if (got != 16) begin nerr++; $display("FAIL toggle_count: got %0d want 16", got); end
    nvec++; if (max_occ > 2) begin nerr++; $display("FAIL toggle_occ: got %0d want <=2", max_occ); end
    repeat (2) @(negedge clk);
    nvec++; if (m_tvalid !== 1'b0) begin nerr++; $display("FAIL toggle_extra: got %0b want 0", m_tvalid); end
    nvec++; if (overrun != 0) begin nerr++; $display("FAIL toggle_overrun: got %0d want 0", overrun); end
  endtask

  task automatic test_mid_reset(input bit async_rst);
    int got = 0;
    m_tready = 1'b0;
    avail += 4;
    repeat (6) @(negedge clk);
    nvec++; if (occupancy !== 2'd2) begin nerr++; $display("FAIL mrst%0b_pre_occ: got %0d want 2", async_rst, occupancy); end
    if (async_rst) begin
      #2 arst_n = 1'b0;
      #1;
      nvec++; if (m_tvalid !== 1'b0 || occupancy !== 2'd0) begin
        nerr++; $display("FAIL mrst1_clear: got v=%0b occ=%0d want v=0 occ=0", m_tvalid, occupancy);
      end
      #1 arst_n = 1'b1;
    end else begin
      rst = 1'b1;
      #1;
      nvec++; if (fifo_r_en !== 1'b0) begin nerr++; $display("FAIL mrst0_rd_en: got %0b want 0", fifo_r_en); end
      @(negedge clk);
      rst = 1'b0;
      nvec++; if (m_tvalid !== 1'b0 || occupancy !== 2'd0 || m_tdata !== '0) begin
        nerr++; $display("FAIL mrst0_clear: got v=%0b occ=%0d d=%0h want 0/0/0", m_tvalid, occupancy, m_tdata);
      end
    end
    exp_w += 2;  // the two buffered words are discarded
    m_tready = 1'b1;
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk);
      if (m_tvalid) begin
        nvec++;
        if (m_tdata !== DATA_W'(exp_w)) begin
          nerr++; $display("FAIL mrst%0b_resume%0d: got %0h want %0h", async_rst, got, m_tdata, exp_w);
        end
        exp_w++; got++;
      end
    end
    nvec++; if (got != 2) begin nerr++; $display("FAIL mrst%0b_count: got %0d want 2", async_rst, got); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_enable();
    int got = 0;
    en = 1'b0; m_tready = 1'b1;
    avail += 3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nvec++; if (fifo_r_en !== 1'b0 || m_tvalid !== 1'b0) begin
        nerr++; $display("FAIL en_off%0d: got rd=%0b v=%0b want 0/0", c, fifo_r_en, m_tvalid);
      end
    end
    en = 1'b1;
    #1;
    nvec++; if (fifo_r_en !== 1'b1) begin nerr++; $display("FAIL en_on: got %0b want 1", fifo_r_en); end
    @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_tvalid) begin
        nvec++;
        if (m_tdata !== DATA_W'(exp_w)) begin nerr++; $display("FAIL en_inflight: got %0h want %0h", m_tdata, exp_w); end
        exp_w++; got++;
      end
    end
    nvec++; if (got != 1) begin nerr++; $display("FAIL en_inflight_count: got %0d want 1", got); end
    nvec++; if (rd_ptr !== avail - 2) begin nerr++; $display("FAIL en_reads: got %0d want %0d", rd_ptr, avail - 2); end
    en = 1'b1; got = 0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      @(negedge clk);
      if (m_tvalid) begin
        nvec++;
        if (m_tdata !== DATA_W'(exp_w)) begin nerr++; $display("FAIL en_rest%0d: got %0h want %0h", got, m_tdata, exp_w); end
        exp_w++; got++;
      end
    end
    nvec++; if (got != 2) begin nerr++; $display("FAIL en_rest_count: got %0d want 2", got); end
    repeat (2) @(negedge clk);
  endtask

`ifdef IOB_FIFO_RD_STREAM_LAST_EN
  task automatic test_last();
    int got;
    // Clear the word counter while idle so packet boundaries start fresh
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cfg_len = LEN_W'(3);
    en = 1'b1; m_tready = 1'b1;
    avail += 7; got = 0;
    for (int c = 0; c < 30 && got < 7; c++) begin
      @(negedge clk);
      if (m_tvalid) begin
        nvec++;
        if (m_tdata !== DATA_W'(exp_w) || m_tlast !== 1'((got == 2) || (got == 5))) begin
          nerr++; $display("FAIL last3_word%0d: got d=%0h l=%0b want d=%0h l=%0b", got, m_tdata, m_tlast, exp_w, (got == 2) || (got == 5));
        end
        exp_w++; got++;
      end
    end
    nvec++; if (got != 7) begin nerr++; $display("FAIL last3_count: got %0d want 7", got); end
    repeat (2) @(negedge clk);
    cfg_len = '0;
    avail += 5; got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      @(negedge clk);
      if (m_tvalid) begin
        nvec++;
        if (m_tdata !== DATA_W'(exp_w) || m_tlast !== 1'b0) begin
          nerr++; $display("FAIL last0_word%0d: got d=%0h l=%0b want d=%0h l=0", got, m_tdata, m_tlast, exp_w);
        end
        exp_w++; got++;
      end
    end
    nvec++; if (got != 5) begin nerr++; $display("FAIL last0_count: got %0d want 5", got); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_mid_reset(1'b0);
    test_mid_reset(1'b1);
    test_enable();
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
    test_last();
`endif
    nvec++; if (overrun != 0) begin nerr++; $display("FAIL final_overrun: got %0d want 0", overrun); end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
